// File: rtl/mov_serializer.sv
// Parallel-to-serial front end for the single-bit mov slice: WIDTH-bit word in, one bit per beat out.
// Bit order is LSB-first by default; define MOV_SER_MSB_FIRST_EN for MSB-first.
//
// state | meaning
// IDLE  | no word held, in_ready=1, out_valid=0
// SHIFT | streaming shreg_q, out_valid=1, cnt_q counts consumed beats
module mov_serializer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_next;
    logic               accept;
    logic               beat;

    assign out_valid = (state_q == SHIFT);
    assign out_last  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    // Ready depends only on state, count and out_ready; a word held by upstream never reaches outputs combinationally.
    assign in_ready  = !rst && ((state_q == IDLE) || (out_last && out_ready));
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid && out_ready;

`ifdef MOV_SER_MSB_FIRST_EN
    assign out_bit    = shreg_q[WIDTH-1];
    assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
`else
    assign out_bit    = shreg_q[0];
    assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (out_last) begin
                        cnt_d = '0;
                        if (accept) begin
                            shreg_d = in_data;
                        end else begin
                            shreg_d = shreg_next;
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shreg_next;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
